opb_single_master: RTL and testbench

Single-beat OPB bus master that lets fabric logic issue 32-bit register reads and writes to OPB slaves, such as the software-visible status and control registers on the same bus. It is the initiator counterpart of the OPB slave register blocks. It sits beside the PPC master on the shared OPB and requests arbitration per transaction. It reports each transaction's completion status back to user logic.

---
 rtl/opb_single_master.sv | 160 ++++++++++++++++
 tb/tb_opb_single_master.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_single_master.sv
// Single-beat OPB master: turns one user read/write request into an arbitrated
// OPB transfer with retry, timeout and error handling, then reports completion.
`timescale 1ns/1ps
module opb_single_master #(
    parameter int C_OPB_AWIDTH     = 32,
    parameter int C_OPB_DWIDTH     = 32,
    parameter int C_TIMEOUT_CYCLES = 16,
    parameter int C_MAX_RETRY      = 4
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_rnw,
    input  logic [C_OPB_AWIDTH-1:0]   req_addr,
    input  logic [C_OPB_DWIDTH/8-1:0] req_be,
    input  logic [C_OPB_DWIDTH-1:0]   req_wdata,
    output logic                      rsp_valid,
    output logic [C_OPB_DWIDTH-1:0]   rsp_rdata,
    output logic [1:0]                rsp_status,
    output logic                      M_request,
    input  logic                      OPB_MGrant,
    output logic                      M_select,
    output logic                      M_RNW,
    output logic [0:C_OPB_AWIDTH-1]   M_ABus,
    output logic [0:C_OPB_DWIDTH/8-1] M_BE,
    output logic [0:C_OPB_DWIDTH-1]   M_DBus,
    output logic                      M_seqAddr,
    output logic                      M_busLock,
    input  logic                      OPB_xferAck,
    input  logic                      OPB_errAck,
    input  logic                      OPB_retry,
    input  logic                      OPB_toutSup,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus
);

    localparam int            BEW         = C_OPB_DWIDTH / 8;
    localparam int            TW          = $clog2(C_TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TOUT_LIMIT  = TW'(C_TIMEOUT_CYCLES);
    localparam logic [3:0]    RETRY_LIMIT = 4'(C_MAX_RETRY);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_RETRY_X = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_BACKOFF,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [C_OPB_AWIDTH-1:0] addr_q;
    logic [BEW-1:0]          be_q;
    logic [C_OPB_DWIDTH-1:0] wdata_q;
    logic                    rnw_q;
    logic [3:0]              retry_cnt;
    logic [TW-1:0]           tout_cnt;

    logic       accept;
    logic       done;
    logic       capture;
    logic       retry_inc;
    logic       slave_resp;
    logic [1:0] done_status;

    assign slave_resp = OPB_errAck | OPB_xferAck | OPB_retry;

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        done        = 1'b0;
        capture     = 1'b0;
        retry_inc   = 1'b0;
        done_status = ST_OK;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (OPB_MGrant) state_nxt = S_XFER;
            end
            S_XFER: begin
                // errAck outranks xferAck so a doubly-acked cycle reports an error
                if (OPB_errAck) begin
                    done        = 1'b1;
                    done_status = ST_ERR;
                end else if (OPB_xferAck) begin
                    done    = 1'b1;
                    capture = rnw_q;
                end else if (OPB_retry) begin
                    if (retry_cnt < RETRY_LIMIT) begin
                        retry_inc = 1'b1;
                        state_nxt = S_BACKOFF;
                    end else begin
                        done        = 1'b1;
                        done_status = ST_RETRY_X;
                    end
                end else if (!OPB_toutSup && tout_cnt == TOUT_LIMIT) begin
                    done        = 1'b1;
                    done_status = ST_TIMEOUT;
                end
                if (done) state_nxt = S_RESP;
            end
            S_BACKOFF: state_nxt = S_REQ;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state      <= S_IDLE;
            retry_cnt  <= '0;
            tout_cnt   <= '0;
            rsp_status <= ST_OK;
            rsp_rdata  <= '0;
        end else begin
            state <= state_nxt;
            if (accept)         retry_cnt <= '0;
            else if (retry_inc) retry_cnt <= retry_cnt + 4'd1;
            // The first XFER cycle counts, so a silent slave times out after
            // C_TIMEOUT_CYCLES+1 bus cycles of select.
            if (state != S_XFER)                   tout_cnt <= '0;
            else if (!slave_resp && !OPB_toutSup)  tout_cnt <= tout_cnt + TW'(1);
            if (done) begin
                rsp_status <= done_status;
                rsp_rdata  <= capture ? OPB_DBus : '0;
            end
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            be_q    <= req_be;
            wdata_q <= req_wdata;
            rnw_q   <= req_rnw;
        end
    end

    // Bus outputs are forced to zero outside select so the OR-combined OPB stays clean.
    assign req_ready = OPB_Rst_n && (state == S_IDLE);
    assign M_request = (state == S_REQ);
    assign M_select  = (state == S_XFER);
    assign M_RNW     = M_select & rnw_q;
    assign M_ABus    = M_select ? addr_q : '0;
    assign M_BE      = M_select ? be_q : '0;
    assign M_DBus    = (M_select && !rnw_q) ? wdata_q : '0;
    assign M_seqAddr = 1'b0;
    assign M_busLock = 1'b0;
    assign rsp_valid = (state == S_RESP);

endmodule

// File: tb/tb_opb_single_master.sv
// Bench for opb_single_master: builds each transaction's expected cycle timeline
// from a transaction plan and compares the DUT against it every cycle.
`timescale 1ns/1ps
module tb_opb_single_master;

    localparam int T    = 16;
    localparam int MAXR = 4;
    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_rnw = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        M_request, M_select, M_RNW, M_seqAddr, M_busLock;
    logic [0:31] M_ABus, M_DBus;
    logic [0:3]  M_BE;
    logic        grant = 1'b0, xack = 1'b0, eack = 1'b0, rty = 1'b0, tsup = 1'b0;
    logic [0:31] opb_dbus = '0;

    opb_single_master #(.C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
                        .C_TIMEOUT_CYCLES(T), .C_MAX_RETRY(MAXR)) dut (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
        .M_request(M_request), .OPB_MGrant(grant), .M_select(M_select),
        .M_RNW(M_RNW), .M_ABus(M_ABus), .M_BE(M_BE), .M_DBus(M_DBus),
        .M_seqAddr(M_seqAddr), .M_busLock(M_busLock),
        .OPB_xferAck(xack), .OPB_errAck(eack), .OPB_retry(rty),
        .OPB_toutSup(tsup), .OPB_DBus(opb_dbus)
    );

    always #5 clk = ~clk;

    // numeric views: bit 0 of the OPB buses is the MSB
    logic [31:0] abus_v, dbus_v;
    logic [3:0]  be_v;
    assign abus_v = M_ABus;
    assign dbus_v = M_DBus;
    assign be_v   = M_BE;

    // expectations for the current cycle, written by the stimulus process
    logic        chk_on = 1'b0;
    logic        e_ready = 0, e_mreq = 0, e_sel = 0, e_rnw = 0, e_rvalid = 0;
    logic [31:0] e_addr = '0, e_dbus = '0, e_rdata = '0;
    logic [3:0]  e_be = '0;
    logic [1:0]  e_status = '0;

    // literal expectations queued by the stimulus process, checked by the compare process
    string       lit_name [64];
    logic [31:0] lit_got  [64];
    logic [31:0] lit_exp  [64];
    int          lit_wr = 0, lit_rd = 0;

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, acc_cyc = 0;
    int xfer_phases = 0, mreq_cycles = 0, sel_start = 0, rsp_cyc = 0;
    logic        prev_sel = 1'b0;
    logic [31:0] last_rdata = '0, last_mdbus = '0, last_abus = '0;
    logic [1:0]  last_status = '0;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, required %h", n, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("M_request", 32'(M_request), 32'(e_mreq));
            chk("M_select", 32'(M_select), 32'(e_sel));
            chk("M_RNW", 32'(M_RNW), 32'(e_rnw));
            chk("M_ABus", abus_v, e_addr);
            chk("M_BE", 32'(be_v), 32'(e_be));
            chk("M_DBus", dbus_v, e_dbus);
            chk("M_seqAddr_busLock", 32'({M_seqAddr, M_busLock}), 32'd0);
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rvalid));
            if (e_rvalid) begin
                chk("rsp_status", 32'(rsp_status), 32'(e_status));
                chk("rsp_rdata", rsp_rdata, e_rdata);
            end
        end
        if (M_select && !prev_sel) begin
            xfer_phases++;
            sel_start = cyc;
        end
        if (M_select) last_abus = abus_v;
        if (M_select && !M_RNW) last_mdbus = dbus_v;
        if (M_request) mreq_cycles++;
        if (rsp_valid) begin
            rsp_cyc     = cyc;
            last_status = rsp_status;
            last_rdata  = rsp_rdata;
        end
        prev_sel = M_select;
        while (lit_rd < lit_wr) begin
            chk(lit_name[lit_rd], lit_got[lit_rd], lit_exp[lit_rd]);
            lit_rd++;
        end
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles, required fewer", cyc);
        $fatal(1, "bench watchdog expired");
    end

    task automatic lit(input string n, input logic [31:0] got, input logic [31:0] exp);
        lit_name[lit_wr] = n;
        lit_got[lit_wr]  = got;
        lit_exp[lit_wr]  = exp;
        lit_wr++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cycle();
        {e_ready, e_mreq, e_sel, e_rnw, e_rvalid} = '0;
        e_addr = '0; e_dbus = '0; e_be = '0; e_rdata = '0; e_status = '0;
        {grant, xack, eack, rty, tsup} = '0;
        opb_dbus = $urandom;
    endtask

    task automatic garble_req();
        req_valid = 1'($urandom_range(0, 1));
        req_rnw   = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_be    = 4'($urandom);
        req_wdata = $urandom;
    endtask

    task automatic xfer_exp(input bit rnw, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wd);
        e_sel  = 1'b1;
        e_rnw  = rnw;
        e_addr = addr;
        e_be   = be;
        e_dbus = rnw ? 32'd0 : wd;
        grant  = 1'($urandom_range(0, 1));
    endtask

    // g: REQ cycles before grant, d: silent XFER cycles before the response,
    // s: toutSup cycles on the final attempt, n_retry: attempts answered with retry
    task automatic run_txn(input bit rnw, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input int g, input int d, input int s,
                           input int n_retry, input int fin, input logic [31:0] rd);
        logic [1:0] st;
        bit finished;
        int a;
        st = 2'b00;
        clear_cycle();
        req_valid = 1'b1; req_rnw = rnw; req_addr = addr; req_be = be; req_wdata = wd;
        e_ready = 1'b1;
        acc_cyc = cyc;
        tick();
        a = 0;
        finished = 0;
        while (!finished) begin
            for (int i = 0; i <= g; i++) begin
                clear_cycle(); garble_req();
                e_mreq = 1'b1;
                grant  = (i == g);
                tick();
            end
            if (a < n_retry) begin
                for (int i = 0; i < d; i++) begin
                    clear_cycle(); garble_req(); xfer_exp(rnw, addr, be, wd); tick();
                end
                clear_cycle(); garble_req(); xfer_exp(rnw, addr, be, wd);
                rty  = 1'b1;
                tsup = 1'($urandom_range(0, 1));
                tick();
                if (a < MAXR) begin
                    clear_cycle(); garble_req(); tick();
                    a++;
                end else begin
                    st = 2'b11;
                    finished = 1;
                end
            end else begin
                for (int i = 0; i < s; i++) begin
                    clear_cycle(); garble_req(); xfer_exp(rnw, addr, be, wd);
                    tsup = 1'b1;
                    tick();
                end
                if (fin == K_NONE) begin
                    for (int i = 0; i <= T; i++) begin
                        clear_cycle(); garble_req(); xfer_exp(rnw, addr, be, wd); tick();
                    end
                    st = 2'b10;
                end else begin
                    for (int i = 0; i < d; i++) begin
                        clear_cycle(); garble_req(); xfer_exp(rnw, addr, be, wd); tick();
                    end
                    clear_cycle(); garble_req(); xfer_exp(rnw, addr, be, wd);
                    tsup = 1'($urandom_range(0, 1));
                    case (fin)
                        K_ACK:  begin xack = 1'b1; opb_dbus = rd; rty = 1'($urandom_range(0, 1)); st = 2'b00; end
                        K_ERR:  begin eack = 1'b1; rty = 1'($urandom_range(0, 1)); st = 2'b01; end
                        default: begin xack = 1'b1; eack = 1'b1; opb_dbus = rd; st = 2'b01; end
                    endcase
                    tick();
                end
                finished = 1;
            end
        end
        clear_cycle(); garble_req();
        e_rvalid = 1'b1;
        e_status = st;
        e_rdata  = (st == 2'b00 && rnw) ? rd : 32'd0;
        tick();
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            clear_cycle();
            req_valid = 1'b0;
            e_ready = 1'b1;
            tick();
        end
    endtask

    initial begin
        int b;
        clear_cycle();
        req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        lit("reset_ready", 32'(req_ready), 32'd0);
        lit("reset_mreq_sel", 32'({M_request, M_select}), 32'd0);
        lit("reset_rvalid", 32'(rsp_valid), 32'd0);
        lit("reset_status_rdata", rsp_rdata | 32'(rsp_status), 32'd0);
        rst_n = 1'b1;
        req_valid = 1'b0;
        e_ready = 1'b1;
        chk_on = 1'b1;
        tick();

        // read, immediate grant, first-cycle ack
        run_txn(1'b1, 32'h4000_0010, 4'hF, 32'h1111_2222, 0, 0, 0, 0, K_ACK, 32'h1234_5678);
        lit("rd_latency", 32'(rsp_cyc - acc_cyc), 32'd3);
        lit("rd_data", last_rdata, 32'h1234_5678);
        lit("rd_status", 32'(last_status), 32'd0);
        lit("rd_abus", last_abus, 32'h4000_0010);

        // write with grant in the fifth REQ cycle
        b = mreq_cycles;
        run_txn(1'b0, 32'h0108_9100, 4'hF, 32'hDEAD_BEEF, 4, 0, 0, 0, K_ACK, 32'h5555_AAAA);
        lit("wr_mreq_cycles", 32'(mreq_cycles - b), 32'd5);
        lit("wr_mdbus", last_mdbus, 32'hDEAD_BEEF);
        lit("wr_status", 32'(last_status), 32'd0);
        lit("wr_rdata", last_rdata, 32'd0);
        gap(1);

        // every attempt retried
        b = xfer_phases;
        run_txn(1'b1, 32'h0000_0ACC, 4'h3, 32'h0, 1, 1, 0, 99, K_ACK, 32'h7777_7777);
        lit("retry_phases", 32'(xfer_phases - b), 32'd5);
        lit("retry_status", 32'(last_status), 32'd3);
        gap(2);

        // silent slave, then toutSup-extended ack
        run_txn(1'b1, 32'h8000_0000, 4'h8, 32'h0, 0, 0, 0, 0, K_NONE, 32'h0);
        lit("tout_latency", 32'(rsp_cyc - sel_start), 32'd17);
        lit("tout_status", 32'(last_status), 32'd2);
        run_txn(1'b1, 32'h8000_0004, 4'hF, 32'h0, 0, 0, 30, 0, K_ACK, 32'h0F0F_1234);
        lit("sup_status", 32'(last_status), 32'd0);
        lit("sup_rdata", last_rdata, 32'h0F0F_1234);

        // xferAck and errAck together
        run_txn(1'b1, 32'h0000_0100, 4'hF, 32'h0, 2, 0, 0, 0, K_BOTH, 32'hFFFF_FFFF);
        lit("both_status", 32'(last_status), 32'd1);
        lit("both_rdata", last_rdata, 32'd0);

        for (int k = 0; k < 40; k++) begin
            int fin, nr, s;
            fin = $urandom_range(0, 9);
            fin = (fin < 5) ? K_ACK : (fin < 7) ? K_ERR : (fin < 9) ? K_BOTH : K_NONE;
            nr  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            s   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 20) : 0;
            run_txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), s, nr, fin, $urandom);
            gap($urandom_range(0, 2));
        end

        // asynchronous reset in the middle of a transfer
        chk_on = 1'b0;
        clear_cycle();
        req_valid = 1'b1; req_rnw = 1'b0; req_addr = 32'hA5A5_0004;
        req_be = 4'hC; req_wdata = 32'h0BAD_F00D;
        tick();
        clear_cycle(); req_valid = 1'b0; grant = 1'b1;
        tick();
        clear_cycle();
        #2;
        lit("rst_pre_sel", 32'(M_select), 32'd1);
        lit("rst_pre_dbus", dbus_v, 32'h0BAD_F00D);
        rst_n = 1'b0;
        #1;
        lit("rst_sel", 32'(M_select), 32'd0);
        lit("rst_bus", abus_v | dbus_v | 32'(be_v) | 32'(M_RNW), 32'd0);
        lit("rst_mreq_ready", 32'({M_request, req_ready}), 32'd0);
        lit("rst_rvalid", 32'(rsp_valid), 32'd0);
        tick();
        lit("rst_hold_rvalid", 32'(rsp_valid), 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        lit("rst_release_ready", 32'(req_ready), 32'd1);
        lit("rst_release_rvalid_sel", 32'({rsp_valid, M_select}), 32'd0);
        clear_cycle();
        e_ready = 1'b1;
        chk_on = 1'b1;
        tick();
        run_txn(1'b1, 32'h0000_0200, 4'hF, 32'h0, 1, 2, 0, 0, K_ACK, 32'hCAFE_0001);
        lit("post_rst_status", 32'(last_status), 32'd0);
        lit("post_rst_rdata", last_rdata, 32'hCAFE_0001);
        gap(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
